// File: rtl/melody_seq_pkg.sv
// Shared definitions for the melody sequencer and the tone generator it feeds:
// note codes, sequencer states and song ROM entry layout.
package melody_seq_pkg;

  localparam int NOTE_W = 3;
  localparam int DUR_W  = 3;
  localparam int IDX_W  = 4;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_REST = 3'd0,
    NOTE_DO   = 3'd1,
    NOTE_RE   = 3'd2,
    NOTE_MI   = 3'd3,
    NOTE_FA   = 3'd4,
    NOTE_SO   = 3'd5,
    NOTE_LA   = 3'd6,
    NOTE_XI   = 3'd7
  } note_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/melody_seq_rom.sv
// Fixed 16-entry song table: index to {note, beats}. Entries past the song are rest/1.
module melody_rom
  import melody_seq_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output rom_entry_t       entry_o
);

  always_comb begin
    // NOTE: the default assignment covers every path, so no latch is inferred.
    entry_o = '{note: NOTE_REST, dur: 3'd1};
    case (idx_i)
      4'd0:    entry_o = '{note: NOTE_DO, dur: 3'd1};
      4'd1:    entry_o = '{note: NOTE_DO, dur: 3'd1};
      4'd2:    entry_o = '{note: NOTE_SO, dur: 3'd1};
      4'd3:    entry_o = '{note: NOTE_SO, dur: 3'd1};
      4'd4:    entry_o = '{note: NOTE_LA, dur: 3'd1};
      4'd5:    entry_o = '{note: NOTE_LA, dur: 3'd1};
      4'd6:    entry_o = '{note: NOTE_SO, dur: 3'd2};
      4'd7:    entry_o = '{note: NOTE_FA, dur: 3'd1};
      4'd8:    entry_o = '{note: NOTE_FA, dur: 3'd1};
      4'd9:    entry_o = '{note: NOTE_MI, dur: 3'd1};
      4'd10:   entry_o = '{note: NOTE_MI, dur: 3'd1};
      4'd11:   entry_o = '{note: NOTE_RE, dur: 3'd1};
      4'd12:   entry_o = '{note: NOTE_RE, dur: 3'd1};
      4'd13:   entry_o = '{note: NOTE_DO, dur: 3'd2};
      default: ;
    endcase
  end

endmodule

// File: rtl/melody_seq.sv
// Song sequencer feeding the PWM tone generator: play/pause, restart and looping.
// Define MELODY_SEQ_GAP_EN to insert GAP_CNT+1 silent cycles between notes.
module melody_seq
  import melody_seq_pkg::*;
#(
  parameter int unsigned TICK_CNT = 24_999_999,
  parameter int unsigned GAP_CNT  = 2_499_999,
  parameter int unsigned SONG_LEN = 14
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              restart,
  input  logic              loop_en,
  output logic [NOTE_W-1:0] note,
  output logic              note_start,
  output logic              playing,
  output logic              song_done
);

  // One counter times both beats and gaps, so it is sized for the longer of the two.
  localparam int unsigned      CNT_MAX   = (TICK_CNT > GAP_CNT) ? TICK_CNT : GAP_CNT;
  localparam int unsigned      CNT_W     = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CNT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SONG_LEN - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  tick_q;
  logic [DUR_W-1:0]  beat_q;
  logic [DUR_W-1:0]  dur_last_q;
  logic [NOTE_W-1:0] cur_note_q;
  logic [NOTE_W-1:0] note_q;
  logic              note_start_q;
  logic              playing_q;
  logic              song_done_q;

  logic [IDX_W-1:0]  load_idx;
  rom_entry_t        rom_entry;
  logic [DUR_W-1:0]  rom_dur_last;
  logic              at_last;
  logic              stop_here;
  logic              note_end;
  logic              advance;
  logic              do_load;
  logic              do_done;
`ifdef MELODY_SEQ_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CNT);
  logic              gap_end;
  logic              go_gap;
`endif

  melody_rom u_rom (
    .idx_i   (load_idx),
    .entry_o (rom_entry)
  );

  always_comb begin
    at_last      = (idx_q == IDX_LAST);
    stop_here    = at_last && !loop_en;
    load_idx     = (state_q == ST_IDLE) ? idx_q : (at_last ? '0 : idx_q + IDX_W'(1));
    rom_dur_last = (rom_entry.dur == '0) ? '0 : rom_entry.dur - DUR_W'(1);
    note_end     = (state_q == ST_NOTE) && play && (tick_q == TICK_LAST) &&
                   (beat_q == dur_last_q);
`ifdef MELODY_SEQ_GAP_EN
    gap_end      = (state_q == ST_GAP) && play && (tick_q == GAP_LAST);
    go_gap       = note_end && !stop_here;
    advance      = gap_end || (note_end && stop_here);
`else
    advance      = note_end;
`endif
    do_load      = ((state_q == ST_IDLE) && play) || (advance && !stop_here);
    do_done      = advance && stop_here;
  end

  // NOTE: state uses non-blocking assignments; every flop is reset, there is no memory array.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      tick_q       <= '0;
      beat_q       <= '0;
      dur_last_q   <= '0;
      cur_note_q   <= NOTE_REST;
      note_q       <= NOTE_REST;
      note_start_q <= 1'b0;
      playing_q    <= 1'b0;
      song_done_q  <= 1'b0;
    end else begin
      note_start_q <= 1'b0;
      song_done_q  <= 1'b0;
      if (restart) begin
        state_q   <= ST_IDLE;
        idx_q     <= '0;
        tick_q    <= '0;
        beat_q    <= '0;
        note_q    <= NOTE_REST;
        playing_q <= 1'b0;
      end else if (do_load) begin
        state_q      <= ST_NOTE;
        idx_q        <= load_idx;
        tick_q       <= '0;
        beat_q       <= '0;
        dur_last_q   <= rom_dur_last;
        cur_note_q   <= rom_entry.note;
        note_q       <= rom_entry.note;
        note_start_q <= 1'b1;
        playing_q    <= 1'b1;
      end else if (do_done) begin
        state_q     <= ST_DONE;
        note_q      <= NOTE_REST;
        playing_q   <= 1'b0;
        song_done_q <= 1'b1;
`ifdef MELODY_SEQ_GAP_EN
      end else if (go_gap) begin
        state_q   <= ST_GAP;
        tick_q    <= '0;
        beat_q    <= '0;
        note_q    <= NOTE_REST;
        playing_q <= 1'b1;
`endif
      end else begin
        case (state_q)
          ST_NOTE: begin
            // Pausing silences the output but freezes the counters, so the note resumes.
            playing_q <= play;
            note_q    <= play ? cur_note_q : NOTE_REST;
            if (play) begin
              if (tick_q == TICK_LAST) begin
                tick_q <= '0;
                beat_q <= beat_q + DUR_W'(1);
              end else begin
                tick_q <= tick_q + CNT_W'(1);
              end
            end
          end
`ifdef MELODY_SEQ_GAP_EN
          ST_GAP: begin
            playing_q <= play;
            if (play) tick_q <= tick_q + CNT_W'(1);
          end
`endif
          default: begin
            note_q    <= NOTE_REST;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign note       = note_q;
  assign note_start = note_start_q;
  assign playing    = playing_q;
  assign song_done  = song_done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Scoreboard bench for melody_seq: expected notes are queued from the song table and
// matched against each note_start, then scored for audible length and trailing silence.
module tb_melody_seq;

  localparam int TICK = 3;
  localparam int GAP  = 1;
  localparam int LEN  = 14;
  localparam int BEAT = TICK + 1;
`ifdef MELODY_SEQ_GAP_EN
  localparam int GAP_CYC = GAP + 1;
`else
  localparam int GAP_CYC = 0;
`endif

  typedef struct {
    logic [2:0] note;
    int         len;
    int         gap;
  } exp_t;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       play    = 1'b0;
  logic       restart = 1'b0;
  logic       loop_en = 1'b0;
  logic [2:0] note;
  logic       note_start;
  logic       playing;
  logic       song_done;

  logic [2:0] song_note [LEN] = '{3'd1, 3'd1, 3'd5, 3'd5, 3'd6, 3'd6, 3'd5,
                                  3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1};
  int         song_dur  [LEN] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};

  exp_t exp_q[$];
  exp_t seg_exp;
  bit   seg_active;
  int   seg_len;
  int   seg_silent;
  int   cyc;
  int   done_cnt;
  int   pass_cnt;
  int   total_cnt;

  melody_seq #(
    .TICK_CNT (TICK),
    .GAP_CNT  (GAP),
    .SONG_LEN (LEN)
  ) dut (
    .sys_clk    (clk),
    .rst_n      (rst_n),
    .play       (play),
    .restart    (restart),
    .loop_en    (loop_en),
    .note       (note),
    .note_start (note_start),
    .playing    (playing),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  task automatic push_entry(input int i, input bit final_stop);
    exp_t e;
    e.note = song_note[i];
    e.len  = song_dur[i] * BEAT;
    e.gap  = final_stop ? 0 : GAP_CYC;
    exp_q.push_back(e);
  endtask

  task automatic close_seg(input bit compare);
    if (seg_active && compare) begin
      total_cnt++;
      if (seg_len !== seg_exp.len)
        $display("FAIL note_len(note %0d): got %0d cycles, want %0d", seg_exp.note, seg_len, seg_exp.len);
      else pass_cnt++;
      total_cnt++;
      if (seg_silent !== seg_exp.gap)
        $display("FAIL gap_len(after note %0d): got %0d cycles, want %0d", seg_exp.note, seg_silent, seg_exp.gap);
      else pass_cnt++;
    end
    seg_active = 1'b0;
  endtask

  // One clock: sample on the falling edge and score against the expected queue.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (song_done) done_cnt++;
    if (note_start) begin
      close_seg(1'b1);
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_note_start: note=%0d at cycle %0d, none queued", note, cyc);
      end else begin
        e = exp_q.pop_front();
        if (note !== e.note)
          $display("FAIL note_value: got %0d, want %0d at cycle %0d", note, e.note, cyc);
        else pass_cnt++;
        seg_exp    = e;
        seg_active = 1'b1;
      end
      seg_len    = 0;
      seg_silent = 0;
    end
    if (seg_active) begin
      if (note != 3'd0 && note == seg_exp.note) seg_len++;
      else if (note == 3'd0 && playing) seg_silent++;
    end
  endtask

  task automatic run_until(input int remaining, input int budget, input string tag);
    int n = 0;
    while (exp_q.size() > remaining && n < budget) begin
      cycle();
      n++;
    end
    total_cnt++;
    if (exp_q.size() > remaining)
      $display("FAIL %s_timeout: %0d notes pending after %0d cycles, want %0d", tag, exp_q.size(), n, remaining);
    else pass_cnt++;
  endtask

  task automatic do_restart();
    play    = 1'b0;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    close_seg(1'b0);
    exp_q.delete();
    cycle();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({note, note_start, playing, song_done} !== 6'b0)
      $display("FAIL reset_outputs: got %b, want 000000", {note, note_start, playing, song_done});
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    total_cnt++;
    if (note !== 3'd0 || playing !== 1'b0)
      $display("FAIL idle_no_play: got note=%0d playing=%0d, want 0/0", note, playing);
    else pass_cnt++;
  endtask

  task automatic test_full_song();
    int n = 0;
    int bad = 0;
    loop_en  = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < LEN; i++) push_entry(i, i == LEN - 1);
    play = 1'b1;
    cycle();
    total_cnt++;
    if (note_start !== 1'b1 || note !== 3'd1)
      $display("FAIL first_note: got start=%0d note=%0d, want 1/1", note_start, note);
    else pass_cnt++;
    run_until(0, 200, "song");
    while (song_done !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    total_cnt++;
    if (song_done !== 1'b1) $display("FAIL song_done_seen: got 0, want 1 within 40 cycles");
    else pass_cnt++;
    total_cnt++;
    if (note !== 3'd0 || playing !== 1'b0)
      $display("FAIL done_outputs: got note=%0d playing=%0d, want 0/0", note, playing);
    else pass_cnt++;
    close_seg(1'b1);
    repeat (12) begin
      cycle();
      if (note !== 3'd0 || playing !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL done_hold: got %0d active cycles, want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL song_done_count: got %0d pulses, want 1", done_cnt);
    else pass_cnt++;
    do_restart();
  endtask

  task automatic test_loop();
    loop_en  = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < LEN; i++) push_entry(i, 1'b0);
    push_entry(0, 1'b0);
    push_entry(1, 1'b0);
    play = 1'b1;
    run_until(0, 250, "loop");
    total_cnt++;
    if (done_cnt !== 0) $display("FAIL loop_no_done: got %0d pulses, want 0", done_cnt);
    else pass_cnt++;
    loop_en = 1'b0;
    do_restart();
  endtask

  task automatic test_pause();
    int bad = 0;
    for (int i = 0; i < 4; i++) push_entry(i, 1'b0);
    play = 1'b1;
    run_until(2, 60, "pause_lead");
    cycle();
    play = 1'b0;
    repeat (10) begin
      cycle();
      if (note !== 3'd0 || playing !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL pause_silence: got %0d active cycles, want 0", bad);
    else pass_cnt++;
    play = 1'b1;
    cycle();
    total_cnt++;
    if (note !== 3'd1 || note_start !== 1'b0 || playing !== 1'b1)
      $display("FAIL pause_resume: got note=%0d start=%0d playing=%0d, want 1/0/1", note, note_start, playing);
    else pass_cnt++;
    run_until(0, 60, "pause_tail");
    do_restart();
  endtask

  task automatic test_restart();
    for (int i = 0; i < 6; i++) push_entry(i, 1'b0);
    play = 1'b1;
    run_until(0, 80, "restart_lead");
    cycle();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    total_cnt++;
    if (note !== 3'd0 || note_start !== 1'b0 || playing !== 1'b0)
      $display("FAIL restart_idle: got note=%0d start=%0d playing=%0d, want 0/0/0", note, note_start, playing);
    else pass_cnt++;
    close_seg(1'b0);
    push_entry(0, 1'b0);
    cycle();
    total_cnt++;
    if (note_start !== 1'b1 || note !== 3'd1)
      $display("FAIL restart_reload: got start=%0d note=%0d, want 1/1", note_start, note);
    else pass_cnt++;
    do_restart();
  endtask

  task automatic test_restart_at_end();
    loop_en  = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < LEN; i++) push_entry(i, i == LEN - 1);
    play = 1'b1;
    run_until(0, 200, "end_lead");
    repeat (7) cycle();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    play    = 1'b0;
    total_cnt++;
    if (song_done !== 1'b0 || note !== 3'd0 || note_start !== 1'b0)
      $display("FAIL restart_beats_end: got done=%0d note=%0d start=%0d, want 0/0/0", song_done, note, note_start);
    else pass_cnt++;
    close_seg(1'b0);
    repeat (3) cycle();
    total_cnt++;
    if (done_cnt !== 0) $display("FAIL restart_done_suppressed: got %0d pulses, want 0", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) push_entry(i, 1'b0);
    play = 1'b1;
    run_until(0, 60, "areset_lead");
    cycle();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({note, note_start, playing, song_done} !== 6'b0)
      $display("FAIL async_reset: got %b, want 000000", {note, note_start, playing, song_done});
    else pass_cnt++;
    close_seg(1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_entry(0, 1'b0);
    cycle();
    total_cnt++;
    if (note_start !== 1'b1 || note !== 3'd1)
      $display("FAIL async_reset_reload: got start=%0d note=%0d, want 1/1", note_start, note);
    else pass_cnt++;
    do_restart();
  endtask

  initial begin
    test_reset();
    test_full_song();
    test_loop();
    test_pause();
    test_restart();
    test_restart_at_end();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
